// File: rtl/ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg
//
// EX/MEM pipeline register. It captures the EX stage results every clock and
// presents them to the MEM stage one cycle later. It also provides:
//   - valid tracking, so that MEM can tell real instructions from bubbles
//   - stall (hold every field) and flush (load a bubble)
//   - PCSrc_out, the registered branch decision, which is sent back to IF
//   - Fwd_En_out, a forwarding tap for the hazard unit
//
// Optional build macro: EXMEM_PERF_CNT_EN
//   When this macro is defined, the block adds the Cnt_clr input and the
//   Retired_cnt_out / Bubble_cnt_out performance counters (CNT_W bits wide).
//
// Ports
//   Clk, Reset            rising-edge clock, synchronous active-high reset
//   Stall, Flush          hold the contents / load a bubble (Flush wins)
//   Valid_in              EX holds a real instruction
//   *_in control bits     RegWrite, MemtoReg, Branch, MemRead, MemWrite
//   ALUAddResult_in       branch target
//   Zero_in               ALU zero flag
//   ALUResult_in          ALU result / memory address
//   ReadData2_in          store data
//   WriteReg_in           destination register index
//   *_out                 registered copies of the fields above, to MEM
//   Valid_out             MEM holds a real instruction
//   PCSrc_out             branch taken (Valid & Branch & Zero)
//   BranchTarget_out      registered branch target
//   Fwd_En_out            the result in MEM can be forwarded
// -----------------------------------------------------------------------------
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
`ifdef EXMEM_PERF_CNT_EN
    , parameter int CNT_W    = 32
`endif
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  Valid_in,
    input  logic                  RegWrite_in,
    input  logic                  MemtoReg_in,
    input  logic                  Branch_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic [DATA_W-1:0]     ALUAddResult_in,
    input  logic                  Zero_in,
    input  logic [DATA_W-1:0]     ALUResult_in,
    input  logic [DATA_W-1:0]     ReadData2_in,
    input  logic [REG_ADDR_W-1:0] WriteReg_in,
    output logic                  RegWrite_out,
    output logic                  MemtoReg_out,
    output logic                  MemRead_out,
    output logic                  MemWrite_out,
    output logic [DATA_W-1:0]     ALUResult_out,
    output logic [DATA_W-1:0]     ReadData2_out,
    output logic [REG_ADDR_W-1:0] WriteReg_out,
    output logic                  Valid_out,
    output logic                  PCSrc_out,
    output logic [DATA_W-1:0]     BranchTarget_out,
`ifdef EXMEM_PERF_CNT_EN
    input  logic                  Cnt_clr,
    output logic [CNT_W-1:0]      Retired_cnt_out,
    output logic [CNT_W-1:0]      Bubble_cnt_out,
`endif
    output logic                  Fwd_En_out
);

    // One pipeline slot. An all-zero slot is a bubble, so both reset and
    // flush load '0.
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  branch;
        logic                  mem_read;
        logic                  mem_write;
        logic                  zero;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     branch_target;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] write_reg;
    } slot_t;

    slot_t slot_d;
    slot_t slot_q;

    // Next-state selection. The order is Flush > Stall > load, and Reset is
    // applied in the register process.
    always_comb begin
        // NOTE: assign a default first so that every path drives slot_d; a
        // path that left it unassigned would infer a latch.
        slot_d = slot_q;
        if (Flush) begin
            slot_d = '0;
        end else if (!Stall) begin
            slot_d.valid         = Valid_in;
            // Control bits are gated with Valid_in so that an invalid slot
            // cannot cause any memory or register-file side effect in later
            // stages.
            slot_d.reg_write     = Valid_in & RegWrite_in;
            slot_d.mem_to_reg    = Valid_in & MemtoReg_in;
            slot_d.branch        = Valid_in & Branch_in;
            slot_d.mem_read      = Valid_in & MemRead_in;
            slot_d.mem_write     = Valid_in & MemWrite_in;
            // The data fields load even for invalid slots.
            slot_d.zero          = Zero_in;
            slot_d.alu_result    = ALUResult_in;
            slot_d.branch_target = ALUAddResult_in;
            slot_d.store_data    = ReadData2_in;
            slot_d.write_reg     = WriteReg_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its value from before the edge and the result does not depend
    // on the order in which processes run.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign RegWrite_out     = slot_q.reg_write;
    assign MemtoReg_out     = slot_q.mem_to_reg;
    assign MemRead_out      = slot_q.mem_read;
    assign MemWrite_out     = slot_q.mem_write;
    assign ALUResult_out    = slot_q.alu_result;
    assign ReadData2_out    = slot_q.store_data;
    assign WriteReg_out     = slot_q.write_reg;
    assign Valid_out        = slot_q.valid;
    assign BranchTarget_out = slot_q.branch_target;

    // These outputs depend only on registered state, so no combinational path
    // runs from EX to IF or to the hazard unit.
    assign PCSrc_out  = slot_q.valid & slot_q.branch & slot_q.zero;
    // A load result (MemtoReg) is not available until after MEM. A write to
    // $0 is never forwarded.
    assign Fwd_En_out = slot_q.valid & slot_q.reg_write & ~slot_q.mem_to_reg
                        & (slot_q.write_reg != '0);

`ifdef EXMEM_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;

    // A flush edge loads a bubble even when Stall is high, so it is counted.
    // A pure stall edge loads nothing and is not counted.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        bubble_cnt_d  = bubble_cnt_q;
        if (Cnt_clr) begin
            retired_cnt_d = '0;
            bubble_cnt_d  = '0;
        end else if (Flush) begin
            bubble_cnt_d  = bubble_cnt_q + 1'b1;
        end else if (!Stall) begin
            if (Valid_in) begin
                retired_cnt_d = retired_cnt_q + 1'b1;
            end else begin
                bubble_cnt_d  = bubble_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            retired_cnt_q <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign Retired_cnt_out = retired_cnt_q;
    assign Bubble_cnt_out  = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
//
// Directed testbench for ex_mem_pipe_reg. Each scenario task drives its
// stimulus and checks the outputs against expected values worked out by hand.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the same
// point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    logic                  Clk = 1'b0;
    logic                  Reset, Stall, Flush, Valid_in;
    logic                  RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in;
    logic [DATA_W-1:0]     ALUAddResult_in, ALUResult_in, ReadData2_in;
    logic                  Zero_in;
    logic [REG_ADDR_W-1:0] WriteReg_in;
    logic                  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
    logic [DATA_W-1:0]     ALUResult_out, ReadData2_out, BranchTarget_out;
    logic [REG_ADDR_W-1:0] WriteReg_out;
    logic                  Valid_out, PCSrc_out, Fwd_En_out;
`ifdef EXMEM_PERF_CNT_EN
    logic                  Cnt_clr;
    logic [31:0]           Retired_cnt_out, Bubble_cnt_out;
`endif

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .Flush            (Flush),
        .Valid_in         (Valid_in),
        .RegWrite_in      (RegWrite_in),
        .MemtoReg_in      (MemtoReg_in),
        .Branch_in        (Branch_in),
        .MemRead_in       (MemRead_in),
        .MemWrite_in      (MemWrite_in),
        .ALUAddResult_in  (ALUAddResult_in),
        .Zero_in          (Zero_in),
        .ALUResult_in     (ALUResult_in),
        .ReadData2_in     (ReadData2_in),
        .WriteReg_in      (WriteReg_in),
        .RegWrite_out     (RegWrite_out),
        .MemtoReg_out     (MemtoReg_out),
        .MemRead_out      (MemRead_out),
        .MemWrite_out     (MemWrite_out),
        .ALUResult_out    (ALUResult_out),
        .ReadData2_out    (ReadData2_out),
        .WriteReg_out     (WriteReg_out),
        .Valid_out        (Valid_out),
        .PCSrc_out        (PCSrc_out),
        .BranchTarget_out (BranchTarget_out),
`ifdef EXMEM_PERF_CNT_EN
        .Cnt_clr          (Cnt_clr),
        .Retired_cnt_out  (Retired_cnt_out),
        .Bubble_cnt_out   (Bubble_cnt_out),
`endif
        .Fwd_En_out       (Fwd_En_out)
    );

    // Advance one clock and settle 1 ns after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Return every EX-side input to an idle, all-zero state.
    task automatic idle_inputs();
        Stall = 0; Flush = 0; Valid_in = 0;
        RegWrite_in = 0; MemtoReg_in = 0; Branch_in = 0; MemRead_in = 0; MemWrite_in = 0;
        ALUAddResult_in = '0; Zero_in = 0; ALUResult_in = '0; ReadData2_in = '0;
        WriteReg_in = '0;
`ifdef EXMEM_PERF_CNT_EN
        Cnt_clr = 0;
`endif
    endtask

    task automatic test_reset();
        Reset = 1; Stall = 1; Flush = 1; Valid_in = 1;
        RegWrite_in = 1; MemtoReg_in = 1; Branch_in = 1; MemRead_in = 1; MemWrite_in = 1;
        ALUAddResult_in = '1; Zero_in = 1; ALUResult_in = '1; ReadData2_in = '1;
        WriteReg_in = '1;
`ifdef EXMEM_PERF_CNT_EN
        Cnt_clr = 1;
`endif
        tick(); tick();
        total++;
        if ({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out});
        else passed++;
        total++;
        if ({ALUResult_out, ReadData2_out, BranchTarget_out} !== '0)
            $display("FAIL reset_data: got %h %h %h expected all 0",
                     ALUResult_out, ReadData2_out, BranchTarget_out);
        else passed++;
        total++;
        if ({Valid_out, PCSrc_out, Fwd_En_out, WriteReg_out} !== '0)
            $display("FAIL reset_status: got v=%b pc=%b fwd=%b wr=%0d expected all 0",
                     Valid_out, PCSrc_out, Fwd_En_out, WriteReg_out);
        else passed++;
        Reset = 0;
        idle_inputs();
    endtask

    task automatic test_basic_load();
        Valid_in = 1; RegWrite_in = 1; ALUResult_in = 32'h0000_00A5; WriteReg_in = 5'd8;
        ReadData2_in = 32'hDEAD_BEEF;
        tick();
        total++;
        if (ALUResult_out !== 32'h0000_00A5)
            $display("FAIL load_alu: got %h expected 000000a5", ALUResult_out);
        else passed++;
        total++;
        if (WriteReg_out !== 5'd8)
            $display("FAIL load_wreg: got %0d expected 8", WriteReg_out);
        else passed++;
        total++;
        if ({Valid_out, RegWrite_out, MemtoReg_out, Fwd_En_out} !== 4'b1101)
            $display("FAIL load_ctrl: got v/rw/m2r/fwd=%b expected 1101",
                     {Valid_out, RegWrite_out, MemtoReg_out, Fwd_En_out});
        else passed++;
        total++;
        if (ReadData2_out !== 32'hDEAD_BEEF)
            $display("FAIL load_store_data: got %h expected deadbeef", ReadData2_out);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_branch();
        Valid_in = 1; Branch_in = 1; Zero_in = 1; ALUAddResult_in = 32'h0000_0040;
        tick();
        total++;
        if ({PCSrc_out, BranchTarget_out} !== {1'b1, 32'h0000_0040})
            $display("FAIL branch_taken: got pcsrc=%b tgt=%h expected 1 00000040",
                     PCSrc_out, BranchTarget_out);
        else passed++;
        Zero_in = 0;
        tick();
        total++;
        if (PCSrc_out !== 1'b0)
            $display("FAIL branch_not_taken: got pcsrc=%b expected 0", PCSrc_out);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_invalid_slot();
        Valid_in = 0; RegWrite_in = 1; MemRead_in = 1; MemWrite_in = 1; Branch_in = 1;
        Zero_in = 1; ALUResult_in = 32'h0000_5A5A; WriteReg_in = 5'd3;
        tick();
        total++;
        if ({Valid_out, RegWrite_out, MemRead_out, MemWrite_out, PCSrc_out, Fwd_En_out} !== 6'b0)
            $display("FAIL invalid_ctrl: got v/rw/mr/mw/pc/fwd=%b expected 000000",
                     {Valid_out, RegWrite_out, MemRead_out, MemWrite_out, PCSrc_out, Fwd_En_out});
        else passed++;
        total++;
        if (ALUResult_out !== 32'h0000_5A5A || WriteReg_out !== 5'd3)
            $display("FAIL invalid_data: got alu=%h wr=%0d expected 00005a5a 3",
                     ALUResult_out, WriteReg_out);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_stall();
        // Load a taken branch so that a pending PCSrc can be seen being held.
        Valid_in = 1; Branch_in = 1; Zero_in = 1; ALUResult_in = 32'h11;
        tick();
        total++;
        if (ALUResult_out !== 32'h11)
            $display("FAIL stall_preload: got %h expected 00000011", ALUResult_out);
        else passed++;
        Stall = 1; ALUResult_in = 32'h22; Branch_in = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ALUResult_out !== 32'h11 || PCSrc_out !== 1'b1)
                $display("FAIL stall_hold_%0d: got alu=%h pcsrc=%b expected 00000011 1",
                         i, ALUResult_out, PCSrc_out);
            else passed++;
        end
        Stall = 0;
        tick();
        total++;
        if (ALUResult_out !== 32'h22 || PCSrc_out !== 1'b0)
            $display("FAIL stall_release: got alu=%h pcsrc=%b expected 00000022 0",
                     ALUResult_out, PCSrc_out);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_flush();
        Valid_in = 1; MemWrite_in = 1; ALUResult_in = 32'h77; ReadData2_in = 32'h99;
        tick();
        total++;
        if (MemWrite_out !== 1'b1 || Valid_out !== 1'b1)
            $display("FAIL flush_preload: got mw=%b v=%b expected 1 1", MemWrite_out, Valid_out);
        else passed++;
        Flush = 1; Stall = 1;
        tick();
        total++;
        if ({MemWrite_out, Valid_out} !== 2'b00 || ALUResult_out !== '0 || ReadData2_out !== '0)
            $display("FAIL flush_bubble: got mw=%b v=%b alu=%h sd=%h expected 0 0 0 0",
                     MemWrite_out, Valid_out, ALUResult_out, ReadData2_out);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_fwd_cases();
        // A write to $0 is passed on to MEM but must not be forwarded.
        Valid_in = 1; RegWrite_in = 1; WriteReg_in = 5'd0;
        tick();
        total++;
        if ({RegWrite_out, Fwd_En_out} !== 2'b10 || WriteReg_out !== 5'd0)
            $display("FAIL fwd_zero_dest: got rw=%b fwd=%b wr=%0d expected 1 0 0",
                     RegWrite_out, Fwd_En_out, WriteReg_out);
        else passed++;
        // A load result cannot be forwarded from MEM.
        MemtoReg_in = 1; WriteReg_in = 5'd5;
        tick();
        total++;
        if (Fwd_En_out !== 1'b0 || MemtoReg_out !== 1'b1)
            $display("FAIL fwd_load: got fwd=%b m2r=%b expected 0 1", Fwd_En_out, MemtoReg_out);
        else passed++;
        // Boundary: the highest register index forwards normally.
        MemtoReg_in = 0; WriteReg_in = 5'd31;
        tick();
        total++;
        if (Fwd_En_out !== 1'b1)
            $display("FAIL fwd_r31: got fwd=%b expected 1", Fwd_En_out);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        Valid_in = 1; RegWrite_in = 1; ALUResult_in = 32'h1234; WriteReg_in = 5'd9;
        tick();
        Stall = 1; Reset = 1;
        tick();
        total++;
        if ({Valid_out, RegWrite_out, Fwd_En_out} !== 3'b000 || ALUResult_out !== '0
            || WriteReg_out !== '0)
            $display("FAIL reset_mid_stall: got v/rw/fwd=%b alu=%h wr=%0d expected 000 0 0",
                     {Valid_out, RegWrite_out, Fwd_En_out}, ALUResult_out, WriteReg_out);
        else passed++;
        Reset = 0;
        idle_inputs();
    endtask

`ifdef EXMEM_PERF_CNT_EN
    task automatic test_perf_cnt();
        Reset = 1;
        tick();
        Reset = 0;
        Valid_in = 1;
        for (int i = 0; i < 5; i++) tick();
        Flush = 1;
        for (int i = 0; i < 2; i++) tick();
        Flush = 0; Stall = 1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (Retired_cnt_out !== 32'd5 || Bubble_cnt_out !== 32'd2)
            $display("FAIL perf_counts: got retired=%0d bubble=%0d expected 5 2",
                     Retired_cnt_out, Bubble_cnt_out);
        else passed++;
        Stall = 0; Cnt_clr = 1;
        tick();
        total++;
        if (Retired_cnt_out !== '0 || Bubble_cnt_out !== '0)
            $display("FAIL perf_clear: got retired=%0d bubble=%0d expected 0 0",
                     Retired_cnt_out, Bubble_cnt_out);
        else passed++;
        idle_inputs();
    endtask
`endif

    initial begin
        Reset = 1;
        idle_inputs();
        #2;
        test_reset();
        test_basic_load();
        test_branch();
        test_invalid_slot();
        test_stall();
        test_flush();
        test_fwd_cases();
        test_reset_mid_stall();
`ifdef EXMEM_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
